// File: rtl/pl_io_in.sv
// -----------------------------------------------------------------------------
// pl_io_in : input-conditioning stage for the pipelined CPU's memory-mapped
//            input ports inp0..inp3.
//
// Synchronises and debounces the slide switches and push-buttons, derives
// press events, sticky press flags and 8-bit per-key press counters, and
// presents them as four registered 32-bit words. Reading the words has no
// side effects; sticky flags are cleared by software through key_clr.
//
// Optional feature (macro PL_IO_IN_IRQ_EN): adds output irq, the registered
// OR of all sticky flags.
//
// Ports:
//   clock    in   1     system clock (same clock as the pipeline registers)
//   resetn   in   1     asynchronous active-low reset
//   sw       in   NSW   raw slide switches, asynchronous, 1 = on
//   key_n    in   NKEY  raw push-buttons, asynchronous, 0 = pressed
//   key_clr  in   NKEY  level clear for sticky press flags (synchronous)
//   inp0     out  32    {zero-pad, debounced sw}
//   inp1     out  32    {zero-pad, debounced key level, 1 = pressed}
//   inp2     out  32    {zero-pad, sticky press flags}
//   inp3     out  32    {cnt3, cnt2, cnt1, cnt0}, cnt0 in bits [7:0]
//   irq      out  1     (PL_IO_IN_IRQ_EN only) OR of sticky flags, registered
// -----------------------------------------------------------------------------
module pl_io_in #(
   parameter int NSW             = 18,
   parameter int NKEY            = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic [NSW-1:0]  sw,
   input  logic [NKEY-1:0] key_n,
   input  logic [NKEY-1:0] key_clr,
   output logic [31:0]     inp0,
   output logic [31:0]     inp1,
   output logic [31:0]     inp2,
   output logic [31:0]     inp3
`ifdef PL_IO_IN_IRQ_EN
   ,
   output logic            irq
`endif
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Two-flop synchronisers. Keys reset to 1 (released, active-low).
   logic [NSW-1:0]  sw_s1, sw_s2;
   logic [NKEY-1:0] key_s1, key_s2;

   // Debounced state and per-bit stability counters.
   logic [NSW-1:0]  sw_db;
   logic [NKEY-1:0] key_db;
   logic [CW-1:0]   sw_cnt  [NSW];
   logic [CW-1:0]   key_cnt [NKEY];

   logic [NKEY-1:0]      key_prev;
   logic [NKEY-1:0]      press;
   logic [NKEY-1:0]      flag;
   logic [NKEY-1:0][7:0] press_cnt;

   // Internal key polarity after the synchroniser: 1 = pressed.
   logic [NKEY-1:0] key_s2_p;
   assign key_s2_p = ~key_s2;

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values of its neighbours, which keeps s1 -> s2 a real two-stage
   // synchroniser instead of collapsing it into one flop.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         key_s1 <= '1;
         key_s2 <= '1;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         key_s1 <= key_n;
         key_s2 <= key_s1;
      end
   end

   // Debounce: a bit's new value is accepted only after it has differed from
   // the stable value for DEBOUNCE_CYCLES consecutive cycles; any return to
   // the stable value restarts the count.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sw_db <= '0;
         for (int i = 0; i < NSW; i++) sw_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NSW; i++) begin
            if (sw_s2[i] == sw_db[i]) begin
               sw_cnt[i] <= '0;
            end else if (sw_cnt[i] == LAST) begin
               sw_db[i]  <= sw_s2[i];
               sw_cnt[i] <= '0;
            end else begin
               sw_cnt[i] <= sw_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         key_db <= '0;
         for (int i = 0; i < NKEY; i++) key_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NKEY; i++) begin
            if (key_s2_p[i] == key_db[i]) begin
               key_cnt[i] <= '0;
            end else if (key_cnt[i] == LAST) begin
               key_db[i]  <= key_s2_p[i];
               key_cnt[i] <= '0;
            end else begin
               key_cnt[i] <= key_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Press is a one-cycle pulse on the debounced 0 -> 1 transition.
   assign press = key_db & ~key_prev;

   // Sticky flags (set beats clear) and wrapping press counters.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         key_prev  <= '0;
         flag      <= '0;
         press_cnt <= '0;
      end else begin
         key_prev <= key_db;
         for (int i = 0; i < NKEY; i++) begin
            if (press[i]) begin
               flag[i]      <= 1'b1;
               press_cnt[i] <= press_cnt[i] + 8'd1;
            end else if (key_clr[i]) begin
               flag[i] <= 1'b0;
            end
         end
      end
   end

`ifdef PL_IO_IN_IRQ_EN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) irq <= 1'b0;
      else         irq <= |flag;
   end
`endif

   // Output words come straight from the state registers; no extra stage.
   assign inp0 = 32'(sw_db);
   assign inp1 = 32'(key_db);
   assign inp2 = 32'(flag);
   assign inp3 = 32'(press_cnt);

endmodule

// File: tb/tb_pl_io_in.sv
// -----------------------------------------------------------------------------
// tb_pl_io_in : self-checking bench for pl_io_in with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_pl_io_in;

   logic        clock;
   logic        resetn;
   logic [17:0] sw;
   logic [3:0]  key_n;
   logic [3:0]  key_clr;
   logic [31:0] inp0, inp1, inp2, inp3;
`ifdef PL_IO_IN_IRQ_EN
   logic        irq;
`endif

   int passed = 0;
   int total  = 0;

   pl_io_in #(.NSW(18), .NKEY(4), .DEBOUNCE_CYCLES(4)) dut (
      .clock   (clock),
      .resetn  (resetn),
      .sw      (sw),
      .key_n   (key_n),
      .key_clr (key_clr),
      .inp0    (inp0),
      .inp1    (inp1),
      .inp2    (inp2),
      .inp3    (inp3)
`ifdef PL_IO_IN_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [17:0] sw;
      logic [3:0]  key_n;
      logic [3:0]  key_clr;
      int          edges;
      logic [31:0] e0, e1, e2, e3;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check4(input string name, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
      check({name, ".inp0"}, inp0, e0);
      check({name, ".inp1"}, inp1, e1);
      check({name, ".inp2"}, inp2, e2);
      check({name, ".inp3"}, inp3, e3);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      vecs[0]  = '{"reset_idle", 18'h0,     4'hF, 4'h0, 1, 32'h0,     32'h0, 32'h0, 32'h0};
      vecs[1]  = '{"sw_edge5",   18'h2A5A5, 4'hF, 4'h0, 5, 32'h0,     32'h0, 32'h0, 32'h0};
      vecs[2]  = '{"sw_edge6",   18'h2A5A5, 4'hF, 4'h0, 1, 32'h2A5A5, 32'h0, 32'h0, 32'h0};
      vecs[3]  = '{"glitch_lo",  18'h2A5A5, 4'hD, 4'h0, 3, 32'h2A5A5, 32'h0, 32'h0, 32'h0};
      vecs[4]  = '{"glitch_hi",  18'h2A5A5, 4'hF, 4'h0, 6, 32'h2A5A5, 32'h0, 32'h0, 32'h0};
      vecs[5]  = '{"k2_edge5",   18'h2A5A5, 4'hB, 4'h0, 5, 32'h2A5A5, 32'h0, 32'h0, 32'h0};
      vecs[6]  = '{"k2_edge6",   18'h2A5A5, 4'hB, 4'h0, 1, 32'h2A5A5, 32'h4, 32'h0, 32'h0};
      vecs[7]  = '{"k2_edge7",   18'h2A5A5, 4'hB, 4'h0, 1, 32'h2A5A5, 32'h4, 32'h4, 32'h00010000};
      vecs[8]  = '{"k2_hold",    18'h2A5A5, 4'hB, 4'h0, 3, 32'h2A5A5, 32'h4, 32'h4, 32'h00010000};
      vecs[9]  = '{"k2_release", 18'h2A5A5, 4'hF, 4'h0, 6, 32'h2A5A5, 32'h0, 32'h4, 32'h00010000};
      vecs[10] = '{"clr_pulse",  18'h2A5A5, 4'hF, 4'h4, 1, 32'h2A5A5, 32'h0, 32'h0, 32'h00010000};
      vecs[11] = '{"clr_low",    18'h2A5A5, 4'hF, 4'h0, 1, 32'h2A5A5, 32'h0, 32'h0, 32'h00010000};

      resetn  = 1'b0;
      sw      = '0;
      key_n   = 4'hF;
      key_clr = '0;
      repeat (3) @(posedge clock);
      #3 resetn = 1'b1;
      @(posedge clock);
      #1;

      // Table-driven vectors: apply inputs, advance, compare all four words.
      for (int v = 0; v < 12; v++) begin
         sw      = vecs[v].sw;
         key_n   = vecs[v].key_n;
         key_clr = vecs[v].key_clr;
         ticks(vecs[v].edges);
         check4(vecs[v].name, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
      end

      // 255 more presses of key 2: cnt2 reaches 255, then wraps to 0.
      for (int i = 0; i < 255; i++) begin
         key_n = 4'hB;
         ticks(7);
         key_n = 4'hF;
         ticks(7);
         if (i == 253) check("cnt2_255", inp3, 32'h00FF0000);
      end
      check("cnt2_wrap", inp3, 32'h0);
      check("flag2_after_wrap", inp2, 32'h4);

      // Clear all flags, then key 0 lands while key_clr[0] is held high.
      key_clr = 4'hF;
      ticks(1);
      check("clr_all", inp2, 32'h0);
      key_clr = 4'h1;
      key_n   = 4'hE;
      ticks(5);
      check("k0_edge5", inp1, 32'h0);
      ticks(1);
      check("k0_edge6_lvl", inp1, 32'h1);
      check("k0_edge6_flag", inp2, 32'h0);
      ticks(1);
      check("set_wins_flag", inp2, 32'h1);
      check("set_wins_cnt", inp3, 32'h00000001);
`ifdef PL_IO_IN_IRQ_EN
      check("irq_lag0", {31'd0, irq}, 32'h0);
`endif
      ticks(1);
      check("clr_after_set", inp2, 32'h0);
`ifdef PL_IO_IN_IRQ_EN
      check("irq_lag1", {31'd0, irq}, 32'h1);
`endif
      ticks(1);
`ifdef PL_IO_IN_IRQ_EN
      check("irq_drop", {31'd0, irq}, 32'h0);
`endif
      check("cnt_unaffected", inp3, 32'h00000001);

      // Asynchronous reset mid-cycle with key 0 still held down.
      key_clr = 4'h0;
      #2 resetn = 1'b0;
      #1;
      check4("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef PL_IO_IN_IRQ_EN
      check("async_rst.irq", {31'd0, irq}, 32'h0);
`endif
      @(posedge clock);
      #3 resetn = 1'b1;
      ticks(5);
      check("post_rst_edge5_lvl", inp1, 32'h0);
      check("post_rst_edge5_sw", inp0, 32'h0);
      ticks(1);
      check("post_rst_edge6_lvl", inp1, 32'h1);
      check("post_rst_edge6_sw", inp0, 32'h2A5A5);
      ticks(1);
      check("post_rst_flag", inp2, 32'h1);
      check("post_rst_cnt", inp3, 32'h00000001);

      // Simultaneous presses of keys 0, 1 and 3.
      key_n = 4'hF;
      ticks(7);
      check("k0_released", inp1, 32'h0);
      key_n = 4'h4;
      ticks(7);
      check4("multi_press", 32'h2A5A5, 32'hB, 32'hB, 32'h01000102);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
